// File: rtl/fir_pkg.sv
// Shared sizing helpers for the FIR filter and its multiplier.
// No logic, no latency; constant functions only.
// No flow control; used at elaboration time.
package fir_pkg;

  // Ceiling log2; used for the tap-index width and the adder-tree growth.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Full-precision accumulator width: one product plus growth from NTAPS adds.
  function automatic int fw(input int dw, input int cw, input int ntaps);
    return dw + cw + clog2(ntaps);
  endfunction

endpackage

// File: rtl/baugh_wooley_mult.sv
// Signed AWxBW multiplier built from a Baugh-Wooley partial-product array.
// Purely combinational, zero cycles of latency.
// No flow control; output follows the inputs.
module baugh_wooley_mult #(
  parameter int AW = 5,
  parameter int BW = 5
) (
  input  logic signed [AW-1:0]    a,
  input  logic signed [BW-1:0]    b,
  output logic signed [AW+BW-1:0] p
);

  localparam int PW = AW + BW;
  // Correction constant absorbing the sign-bit weights of both operands.
  localparam logic [PW-1:0] K = (PW'(1) << (AW - 1)) + (PW'(1) << (BW - 1)) + (PW'(1) << (PW - 1));

  logic [PW-1:0] acc;
  logic          pp;

  // Sum all partial products; terms pairing exactly one sign bit are inverted.
  always_comb begin
    acc = K;
    pp  = 1'b0;
    for (int i = 0; i < AW; i++) begin
      for (int j = 0; j < BW; j++) begin
        pp = a[i] & b[j];
        if ((i == AW - 1) != (j == BW - 1)) pp = ~pp;
        acc = acc + (PW'(pp) << (i + j));
      end
    end
  end

  assign p = signed'(acc);

endmodule

// File: rtl/fir_filter_n.sv
// Direct-form NTAPS-tap FIR with runtime-writable coefficients and width fitting.
// Latency 2 cycles from in_valid to out_valid (product stage, sum stage).
// No backpressure: a sample is accepted every in_valid cycle, 1 sample/cycle.
module fir_filter_n
  import fir_pkg::*;
#(
  parameter int DW    = 5,
  parameter int CW    = 5,
  parameter int NTAPS = 4,
  parameter int OW    = 12,
  parameter int SAT   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [DW-1:0]      x_in,
  input  logic                      coef_we,
  input  logic [clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]      coef_data,
  output logic                      out_valid,
  output logic signed [OW-1:0]      y_out
);

  localparam int FW = fw(DW, CW, NTAPS);
  localparam int PW = DW + CW;
  localparam int XW = (OW > FW) ? OW : FW;
  localparam logic signed [XW-1:0] YMAX = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] YMIN = ~YMAX;

  logic signed [DW-1:0] d    [NTAPS];
  logic signed [DW-1:0] tap  [NTAPS];
  logic signed [CW-1:0] coef [NTAPS];
  logic signed [PW-1:0] prod [NTAPS];
  logic signed [PW-1:0] p_q  [NTAPS];
  logic signed [FW-1:0] sum_c;
  logic signed [FW-1:0] sum_q;
  logic                 v1;
  logic                 v2;

  // Clamp to the OW range when saturating and narrowing, otherwise wrap or sign-extend.
  function automatic logic signed [OW-1:0] fit_width(input logic signed [FW-1:0] s);
    logic signed [XW-1:0] sx;
    sx = XW'(s);
    if (SAT != 0 && OW < FW) begin
      if (sx > YMAX) return OW'(YMAX);
      if (sx < YMIN) return OW'(YMIN);
    end
    return OW'(sx);
  endfunction

  // Tap 0 is the incoming sample so the newest sample is used in its own cycle.
  always_comb begin
    tap[0] = x_in;
    for (int k = 1; k < NTAPS; k++) tap[k] = d[k-1];
  end

  for (genvar g = 0; g < NTAPS; g++) begin : g_mult
    baugh_wooley_mult #(.AW(CW), .BW(DW)) u_mult (
      .a (coef[g]),
      .b (tap[g]),
      .p (prod[g])
    );
  end

  // Delay line advances only on accepted samples and holds through bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) d[k] <= '0;
    end else if (in_valid) begin
      d[0] <= x_in;
      for (int k = 1; k < NTAPS; k++) d[k] <= d[k-1];
    end
  end

  // Coefficient bank; a same-cycle sample still sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
    end else if (coef_we && int'(coef_addr) < NTAPS) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // Stage 1: capture all products for the accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      for (int k = 0; k < NTAPS; k++) p_q[k] <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < NTAPS; k++) p_q[k] <= prod[k];
      end
    end
  end

  // Full-precision sign-extended sum of the registered products.
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NTAPS; k++) sum_c = sum_c + FW'(p_q[k]);
  end

  // Stage 2: capture the sum; held while no new result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      sum_q <= '0;
    end else begin
      v2 <= v1;
      if (v1) sum_q <= sum_c;
    end
  end

  assign out_valid = v2;
  assign y_out     = fit_width(sum_q);

endmodule
